inverse_cdf_scheduler: RTL and testbench

- Shares one inverse-CDF pipeline (fold step followed by the downstream Gaussian stages) among NUM_REQ Sobol dimension streams.
- Round-robin arbitrates the requesters into a registered issue stage.
- Records the requester ID of each issued sample in an in-order tag FIFO.
- Routes each returning z-score to the requester that issued it.
- Bounds in-flight samples to MAX_OUT so the shared pipeline can never hold more samples than the tag FIFO can track.

---
 rtl/inverse_cdf_scheduler.sv | 157 +++++++++++++++
 tb/tb_inverse_cdf_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_cdf_scheduler.sv
// Round-robin scheduler sharing one inverse-CDF pipeline among NUM_REQ Sobol streams.
// An in-order tag FIFO routes each returning z-score back to the requester that issued it.
package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
endpackage

module inverse_cdf_scheduler #(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_u,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     pipe_valid,
    output logic [WIDTH-1:0]         pipe_u,
    input  logic                     pipe_ready,
    input  logic                     res_valid,
    input  logic [WIDTH-1:0]         res_z,
    output logic                     res_ready,
    output logic [NUM_REQ-1:0]       out_valid,
    output logic [WIDTH-1:0]         out_z,
    input  logic [NUM_REQ-1:0]       out_ready,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_orphan
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    logic               r_pipe_valid;
    logic [WIDTH-1:0]   r_pipe_u;
    logic [TAG_W-1:0]   r_issue_tag;
    logic [TAG_W-1:0]   r_rr_ptr;
    logic [TAG_W-1:0]   r_fifo [MAX_OUT];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_err_orphan;

    logic               w_issue_hs;
    logic               w_res_hs;
    logic               w_fifo_empty;
    logic               w_load_ok;
    logic               w_load;
    logic               w_found;
    logic [TAG_W-1:0]   w_win;
    logic [TAG_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_rr_next;
    logic [TAG_W-1:0]   w_head;
    logic [CNT_W-1:0]   w_in_flight;
    logic [WIDTH-1:0]   w_sel_u;

    assign w_issue_hs   = r_pipe_valid & pipe_ready;
    assign w_res_hs     = res_valid & res_ready;
    // FIFO occupancy equals the handshaked in-flight count, so empty needs no separate flag
    assign w_fifo_empty = (r_outstanding == '0);
    assign w_head       = r_fifo[r_rd_ptr];

    // the sample waiting in the issue register reserves a slot before it handshakes
    assign w_in_flight  = r_outstanding + CNT_W'(r_pipe_valid);
    assign w_load_ok    = (!r_pipe_valid | pipe_ready) & (w_in_flight < CNT_W'(MAX_OUT));
    assign w_load       = w_load_ok & w_found;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = TAG_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_rr_next = (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_sel_u = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == TAG_W'(i)) begin
                w_sel_u = req_u[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_load) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        out_valid = '0;
        if (res_valid && !w_fifo_empty) begin
            out_valid[w_head] = 1'b1;
        end
    end

    assign res_ready   = !w_fifo_empty && out_ready[w_head];
    assign out_z       = res_z;
    assign pipe_valid  = r_pipe_valid;
    assign pipe_u      = r_pipe_u;
    assign outstanding = r_outstanding;
    assign err_orphan  = r_err_orphan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_valid  <= 1'b0;
            r_pipe_u      <= '0;
            r_issue_tag   <= '0;
            r_rr_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_err_orphan  <= 1'b0;
        end else begin
            if (w_load) begin
                r_pipe_valid <= 1'b1;
                r_pipe_u     <= w_sel_u;
                r_issue_tag  <= w_win;
                r_rr_ptr     <= w_rr_next;
            end else if (pipe_ready) begin
                r_pipe_valid <= 1'b0;
            end
            if (w_issue_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_res_hs) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_issue_hs && !w_res_hs) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_issue_hs && w_res_hs) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (res_valid && w_fifo_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue_hs) begin
            r_fifo[r_wr_ptr] <= r_issue_tag;
        end
    end

    a_fifo_never_overflows: assert property (@(posedge clk) disable iff (rst)
        (w_issue_hs && !w_res_hs) |-> (r_outstanding < CNT_W'(MAX_OUT)));

endmodule

// File: tb/tb_inverse_cdf_scheduler.sv
// Randomized bench for inverse_cdf_scheduler: a queue-based reference model is checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inverse_cdf_scheduler;
    localparam int NR = 4;
    localparam int MO = 8;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*W-1:0] req_u = '0;
    logic [NR-1:0]   req_ready;
    logic            pipe_valid;
    logic [W-1:0]    pipe_u;
    logic            pipe_ready = 1'b0;
    logic            res_valid = 1'b0;
    logic [W-1:0]    res_z = '0;
    logic            res_ready;
    logic [NR-1:0]   out_valid;
    logic [W-1:0]    out_z;
    logic [NR-1:0]   out_ready = '0;
    logic [3:0]      outstanding;
    logic            err_orphan;

    inverse_cdf_scheduler #(.WIDTH(W), .NUM_REQ(NR), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_u(req_u), .req_ready(req_ready),
        .pipe_valid(pipe_valid), .pipe_u(pipe_u), .pipe_ready(pipe_ready),
        .res_valid(res_valid), .res_z(res_z), .res_ready(res_ready),
        .out_valid(out_valid), .out_z(out_z), .out_ready(out_ready),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // stand-in for the Gaussian stages: fixed point for u=0.25, otherwise a reversible scramble
    function automatic logic [W-1:0] zfun(input logic [W-1:0] u);
        if (u == 32'h0000_4000) return 32'hFFFF_5350;
        return {u[15:0], u[31:16]} ^ 32'h0000_FFFF;
    endfunction

    // reference model: issue slot plus a queue of in-flight (tag, sample) pairs
    bit           m_pv = 1'b0;
    logic [W-1:0] m_pu = '0;
    int           m_ptag = 0;
    int           m_rr = 0;
    bit           m_err = 1'b0;
    int           tq[$];
    logic [W-1:0] uq[$];
    int           dcount[NR];

    int            e_win;
    bit            e_ld, e_empty, e_rres;
    logic [NR-1:0] e_rreq, e_oval;

    task automatic compute_exp();
        e_win = -1;
        for (int k = 0; k < NR; k++) begin
            if (e_win < 0 && req_valid[(m_rr + k) % NR]) e_win = (m_rr + k) % NR;
        end
        e_ld    = (!m_pv || pipe_ready) && (tq.size() + int'(m_pv) < MO) && (e_win >= 0);
        e_rreq  = '0;
        if (e_ld) e_rreq[e_win] = 1'b1;
        e_empty = (tq.size() == 0);
        e_rres  = !e_empty && out_ready[tq[0]];
        e_oval  = '0;
        if (res_valid && !e_empty) e_oval[tq[0]] = 1'b1;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pv = 1'b0; m_pu = '0; m_ptag = 0; m_rr = 0; m_err = 1'b0;
            tq.delete(); uq.delete();
        end else begin
            bit ihs, rhs;
            compute_exp();
            ihs = m_pv && pipe_ready;
            rhs = res_valid && e_rres;
            if (res_valid && e_empty) m_err = 1'b1;
            if (rhs) begin
                void'(tq.pop_front());
                void'(uq.pop_front());
            end
            if (ihs) begin
                tq.push_back(m_ptag);
                uq.push_back(m_pu);
            end
            if (e_ld) begin
                m_pu   = req_u[e_win*W +: W];
                m_ptag = e_win;
                m_pv   = 1'b1;
                m_rr   = (e_win + 1) % NR;
            end else if (pipe_ready) begin
                m_pv = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        compute_exp();
        chk("req_ready", req_ready, e_rreq);
        chk("pipe_valid", pipe_valid, m_pv);
        chk("pipe_u", pipe_u, m_pu);
        chk("res_ready", res_ready, e_rres);
        chk("out_valid", out_valid, e_oval);
        chk("outstanding", outstanding, tq.size());
        chk("err_orphan", err_orphan, m_err);
        if (res_valid && e_rres) begin
            chk("out_z", out_z, zfun(uq[0]));
            dcount[tq[0]]++;
        end
    end

    // stimulus knobs and the environment's view of the shared pipeline
    logic [NR-1:0] rq_mask = '0;
    int            rq_pct = 0;
    bit            use_fix = 1'b0;
    logic [W-1:0]  fix_u[NR];
    int            pr_pct = 0;
    logic [NR-1:0] or_mask = '0;
    int            or_pct = 0;
    int            res_pct = 0;
    bit            force_res = 1'b0;
    logic [W-1:0]  env_q[$];

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]    = rq_mask[i] && ($urandom_range(99) < rq_pct);
            req_u[i*W +: W] = use_fix ? fix_u[i] : W'($urandom);
            out_ready[i]    = or_mask[i] && ($urandom_range(99) < or_pct);
        end
        pipe_ready = ($urandom_range(99) < pr_pct);
        if (force_res) begin
            res_valid = 1'b1;
            res_z     = W'($urandom);
        end else begin
            res_valid = (env_q.size() > 0) && ($urandom_range(99) < res_pct);
            res_z     = (env_q.size() > 0) ? zfun(env_q[0]) : '0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        if (res_valid && res_ready) void'(env_q.pop_front());
        if (pipe_valid && pipe_ready) env_q.push_back(pipe_u);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; res_valid = 1'b0; pipe_ready = 1'b0; out_ready = '0;
        env_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        rq_mask = '0; res_pct = 100; pr_pct = 100; or_mask = '1; or_pct = 100; force_res = 1'b0;
        for (int c = 0; c < 60 && (outstanding != 0 || pipe_valid); c++) cycle();
        chk("drained", {pipe_valid, outstanding}, 0);
    endtask

    int n_iss;
    int g;
    int dsum;

    initial begin
        for (int i = 0; i < NR; i++) fix_u[i] = W'(32'h1000 * (i + 1));
        do_reset();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_pipe_valid", pipe_valid, 0);
        chk("rst_err", err_orphan, 0);

        // single sample from requester 0
        fix_u[0] = 32'h0000_4000;
        use_fix = 1'b1; rq_mask = 4'b0001; rq_pct = 100; pr_pct = 100;
        or_mask = '1; or_pct = 100; res_pct = 100;
        cycle();
        chk("t1_req_ready", req_ready, 4'b0001);
        rq_mask = '0;
        cycle();
        chk("t1_pipe_valid", pipe_valid, 1);
        chk("t1_pipe_u", pipe_u, 32'h0000_4000);
        cycle();
        chk("t1_outstanding1", outstanding, 1);
        chk("t1_out_valid", out_valid, 4'b0001);
        chk("t1_out_z", out_z, 32'hFFFF_5350);
        chk("t1_res_ready", res_ready, 1);
        cycle();
        chk("t1_outstanding0", outstanding, 0);
        fix_u[0] = 32'h0000_1000;

        // all requesters saturating, echo pipeline
        do_reset();
        for (int i = 0; i < NR; i++) dcount[i] = 0;
        use_fix = 1'b0; rq_mask = '1; rq_pct = 100; pr_pct = 100; res_pct = 100;
        g = 0; dsum = 0;
        for (int c = 0; c < 1200 && dsum < 400; c++) begin
            cycle();
            if (req_ready != 0) begin
                chk("t2_grant", req_ready, 4'b0001 << (g % NR));
                g++;
            end
            dsum = dcount[0] + dcount[1] + dcount[2] + dcount[3];
        end
        chk("t2_total", dsum, 400);
        for (int i = 0; i < NR; i++) chk("t2_per_req", dcount[i], 100);

        // pipeline never returns: in-flight cap
        do_reset();
        rq_mask = '1; rq_pct = 100; pr_pct = 100; res_pct = 0;
        n_iss = 0;
        repeat (20) begin
            cycle();
            if (pipe_valid && pipe_ready) n_iss++;
        end
        chk("t3_issues", n_iss, 8);
        chk("t3_outstanding", outstanding, 8);
        chk("t3_req_ready", req_ready, 0);
        res_pct = 100;
        cycle();
        if (pipe_valid && pipe_ready) n_iss++;
        res_pct = 0;
        repeat (10) begin
            cycle();
            if (pipe_valid && pipe_ready) n_iss++;
        end
        chk("t3_issues_after_one", n_iss, 9);
        chk("t3_outstanding_after", outstanding, 8);
        drain();

        // pipe_ready stall with a sample held
        use_fix = 1'b1; pr_pct = 0; rq_mask = 4'b0100; rq_pct = 100;
        cycle();
        chk("t4_load", req_ready, 4'b0100);
        rq_mask = '1;
        repeat (5) begin
            cycle();
            chk("t4_hold_valid", pipe_valid, 1);
            chk("t4_hold_u", pipe_u, 32'h0000_3000);
            chk("t4_req_ready", req_ready, 0);
        end
        pr_pct = 100;
        cycle();
        chk("t4_next_grant", req_ready, 4'b1000);
        drain();

        // result for requester 2 blocked by its consumer
        use_fix = 1'b1; rq_mask = 4'b0100; rq_pct = 100; or_mask = 4'b1011;
        cycle();
        chk("t5_issue", req_ready, 4'b0100);
        rq_mask = '0;
        cycle();
        repeat (3) begin
            cycle();
            chk("t5_out_valid", out_valid, 4'b0100);
            chk("t5_res_ready", res_ready, 0);
            chk("t5_outstanding", outstanding, 1);
        end
        or_mask = '1;
        cycle();
        chk("t5_release_ready", res_ready, 1);
        chk("t5_release_valid", out_valid, 4'b0100);
        cycle();
        chk("t5_retired", outstanding, 0);

        // orphan result
        force_res = 1'b1;
        cycle();
        chk("t6_orphan_ready", res_ready, 0);
        chk("t6_orphan_valid", out_valid, 0);
        force_res = 1'b0;
        repeat (3) begin
            cycle();
            chk("t6_err_sticky", err_orphan, 1);
        end

        // async reset pulse mid-traffic
        use_fix = 1'b0; rq_mask = '1; rq_pct = 80; pr_pct = 80; res_pct = 60; or_pct = 80;
        repeat (30) cycle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_pipe_valid", pipe_valid, 0);
        chk("t6_async_outstanding", outstanding, 0);
        chk("t6_async_err", err_orphan, 0);
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_res_ready", res_ready, 0);
        req_valid = '0; res_valid = 1'b0; env_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // random traffic
        rq_mask = '1; rq_pct = 60; pr_pct = 70; res_pct = 60; or_mask = '1; or_pct = 70;
        repeat (3000) cycle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
